sw4_alloc: RTL and testbench
============================

Name: sw4_alloc

Overview:
- Wormhole switch allocator and output stage for one radix-4 butterfly switch node.
- Accepts four flit streams, arbitrates round-robin for each output, and holds a grant from head flit to tail flit.
- Registers the winning flit onto each output with valid/ready flow control.
- Instantiated once per node in every layer of the 64-port symmetrical butterfly. ADR_LSB selects the destination digit each layer routes on: 4 for layer 1, 2 for layer 2, 0 for layer 3.

Parameters:
- CHANNEL_WIDTH, 18: flit width. Bit 17 = head, bit 16 = tail, bits 15:0 = payload.
- ADR_LSB, 0: LSB of the 2-bit output-select field within the head-flit payload (bits ADR_LSB+1:ADR_LSB).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  4  per-input flit valid
- in_ch  in  4x18  per-input flit
- in_rdy  out  4  per-input flit accepted this cycle
- out_vld  out  4  per-output registered flit valid
- out_ch  out  4x18  per-output registered flit
- out_rdy  in  4  downstream accepts output flit
- err_proto  out  1  sticky protocol error

Behaviour:
- Reset state, asynchronous on rst_n low: out_vld=0, out_ch=0, err_proto=0, every output IDLE, every owner=0, every rr_ptr=0. in_rdy is combinational, so it is 0 while in reset.
- Output stage o is free when !out_vld[o] or out_rdy[o]. A transfer into a free stage loads out_ch[o] and sets out_vld[o]=1. A free stage with no transfer clears out_vld[o]. Latency from input accept to out_vld is 1 cycle.
- Request rule: input i requests output d when in_vld[i]=1, in_ch[i][17]=1 and d = in_ch[i][ADR_LSB+1:ADR_LSB].
- Per-output FSM, IDLE state:
  - The grant goes to the first requester found searching i = rr_ptr, rr_ptr+1, … mod 4.
  - A grant is issued only if the stage is free. Then in_rdy[g]=1, the flit is transferred and rr_ptr = (g+1) mod 4.
  - If the head flit's tail bit is 0, the FSM goes to LOCKED with owner=g.
  - If the head flit's tail bit is 1 (single-flit packet), the FSM stays IDLE.
  - If the stage is not free, there is no grant and rr_ptr is unchanged.
- Per-output FSM, LOCKED state:
  - Only the owner is served. in_rdy[owner]=1 when in_vld[owner]=1, in_ch[owner][17]=0 and the stage is free.
  - A transferred flit with tail=1 returns the FSM to IDLE.
  - A new head cannot be granted in the same cycle as a tail; there is a minimum 1-cycle gap between packets on an output.
- Body flit from input i (head=0) is routed to the output that is LOCKED with owner=i. If no such output exists, the flit is never accepted and err_proto is set.
- Head flit from an input that already owns a LOCKED output is held (in_rdy=0) until that packet's tail has passed; err_proto is set.
- An input is accepted by at most one output per cycle. in_rdy may depend on in_vld; the upstream must not depend on in_rdy to drive in_vld.
- Outputs are fully independent: four concurrent packets from four distinct inputs to four distinct outputs sustain 1 flit/cycle each.
- Reset asserted mid-packet aborts every lock and drops in-flight output flits. No recovery state is kept.

Decomposition:
- Package sym_bfly_pkg holds:
  - constants RADIX=4, HEAD_BIT=17, TAIL_BIT=16, PAYLOAD_W=16;
  - flit struct {head, tail, payload};
  - enum alloc_state_e {IDLE, LOCKED}.
- One sub-module, rr_arb4: 4-request round-robin arbiter with a ptr input, returning a one-hot grant and a valid flag. It is instantiated once per output.
- FSM, owner, output register and routing mux live in sw4_alloc.

Test Plan:
- Single flit, ADR_LSB=0: in_ch[2]={head=1, tail=1, payload=16'h0003} with in_vld[2]=1 and out_rdy=4'hF. Required: in_rdy=4'b0100 in that cycle; next cycle out_vld=4'b1000 and out_ch[3]=18'h30003; output 3 stays IDLE.
- Contention: inputs 0–3 each present a single-flit head to output 1 every cycle, out_rdy=1. Required: grants 0,1,2,3,0 on consecutive cycles; each input gets 1 grant in 4 cycles.
- Wormhole lock: input 1 sends a 4-flit packet (head dest 2, two bodies, tail) while input 0 sends a head to dest 2 at cycle 1. Required: input 0 is blocked until the cycle after input 1's tail transfers, then granted; output 2 carries 4 contiguous input-1 flits.
- Backpressure: out_rdy[0]=0 for 3 cycles mid-packet. Required: out_ch[0] holds steady, in_rdy of the owner is 0, no flit is lost or duplicated; flow resumes at 1 flit/cycle when out_rdy[0]=1.
- ADR_LSB=4 routing: a head with payload 16'h0020 goes to output 2. A body flit arriving on an unlocked input is never accepted and err_proto=1 stays set.
- Reset mid-packet: assert rst_n=0 during the second flit of a 3-flit packet. Required: out_vld=0 immediately; after release all outputs are IDLE and a fresh head is granted normally.

Source files
------------

// File: rtl/sym_bfly_pkg.sv
// sym_bfly_pkg: shared flit format, allocator state and helpers for the butterfly switch
package sym_bfly_pkg;
  localparam int RADIX     = 4;
  localparam int HEAD_BIT  = 17;
  localparam int TAIL_BIT  = 16;
  localparam int PAYLOAD_W = 16;

  typedef struct packed {
    logic                 head;
    logic                 tail;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  // one-hot (at most one bit set) to binary index
  function automatic logic [1:0] oh2idx(input logic [RADIX-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < RADIX; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction
endpackage

// File: rtl/sw4_alloc_rr_arb4.sv
// rr_arb4: 4-request round-robin arbiter, search starts at ptr
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       vld
);
  logic [1:0] idx;
  // scan from farthest to nearest so the requester closest to ptr wins
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt = 4'b0001 << idx;
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sw4_alloc.sv
// sw4_alloc: radix-4 wormhole switch allocator with registered output stage
module sw4_alloc
  import sym_bfly_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 18,
  parameter int ADR_LSB       = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [RADIX-1:0]                      in_vld,
  input  logic [RADIX-1:0][CHANNEL_WIDTH-1:0]   in_ch,
  output logic [RADIX-1:0]                      in_rdy,
  output logic [RADIX-1:0]                      out_vld,
  output logic [RADIX-1:0][CHANNEL_WIDTH-1:0]   out_ch,
  input  logic [RADIX-1:0]                      out_rdy,
  output logic                                  err_proto
);
  alloc_state_e                          state_q [RADIX];
  alloc_state_e                          state_d [RADIX];
  logic [RADIX-1:0][1:0]                 owner_q, owner_d;
  logic [RADIX-1:0][1:0]                 rr_ptr_q, rr_ptr_d;
  logic [RADIX-1:0]                      out_vld_q, out_vld_d;
  logic [RADIX-1:0][CHANNEL_WIDTH-1:0]   out_ch_q, out_ch_d;
  logic                                  err_q, err_d;
  logic [RADIX-1:0]                      owns, free, arb_vld;
  logic [RADIX-1:0][RADIX-1:0]           req, arb_gnt, sel;
  logic [1:0]                            gi;

  // decode head requests per output; inputs already holding a lock may not request
  always_comb begin
    owns = '0;
    free = '0;
    req  = '0;
    for (int o = 0; o < RADIX; o++) begin
      free[o] = !out_vld_q[o] || out_rdy[o];
      for (int i = 0; i < RADIX; i++)
        if (state_q[o] == LOCKED && owner_q[o] == 2'(i)) owns[i] = 1'b1;
    end
    for (int o = 0; o < RADIX; o++)
      for (int i = 0; i < RADIX; i++)
        req[o][i] = in_vld[i] && in_ch[i][HEAD_BIT] && !owns[i] &&
                    in_ch[i][ADR_LSB+1:ADR_LSB] == 2'(o);
  end

  for (genvar o = 0; o < RADIX; o++) begin : g_arb
    rr_arb4 u_arb (
      .req (req[o]),
      .ptr (rr_ptr_q[o]),
      .gnt (arb_gnt[o]),
      .vld (arb_vld[o])
    );
  end

  // pick the input each free output takes this cycle: arbiter winner or lock owner's body flit
  always_comb begin
    sel    = '0;
    in_rdy = '0;
    for (int o = 0; o < RADIX; o++)
      for (int i = 0; i < RADIX; i++)
        sel[o][i] = free[o] && (state_q[o] == IDLE ? arb_vld[o] && arb_gnt[o][i]
                                                   : owner_q[o] == 2'(i) && in_vld[i] && !in_ch[i][HEAD_BIT]);
    for (int i = 0; i < RADIX; i++)
      for (int o = 0; o < RADIX; o++)
        in_rdy[i] = in_rdy[i] | sel[o][i];
    in_rdy = in_rdy & {RADIX{rst_n}};
  end

  // output register, lock FSM, round-robin pointer and sticky protocol error
  always_comb begin
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    out_vld_d = out_vld_q;
    out_ch_d  = out_ch_q;
    err_d     = err_q;
    gi        = '0;
    for (int o = 0; o < RADIX; o++) begin
      state_d[o] = state_q[o];
      gi = oh2idx(sel[o]);
      if (free[o]) begin
        out_vld_d[o] = |sel[o];
        if (|sel[o]) out_ch_d[o] = in_ch[gi];
      end
      if (|sel[o] && state_q[o] == IDLE) begin
        rr_ptr_d[o] = gi + 2'd1;
        if (!in_ch[gi][TAIL_BIT]) begin
          state_d[o] = LOCKED;
          owner_d[o] = gi;
        end
      end else if (|sel[o] && in_ch[gi][TAIL_BIT]) begin
        state_d[o] = IDLE;
      end
    end
    for (int i = 0; i < RADIX; i++)
      if (in_vld[i] && (in_ch[i][HEAD_BIT] ? owns[i] : !owns[i])) err_d = 1'b1;
  end

  // state registers; reset aborts every lock and drops in-flight flits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < RADIX; o++) state_q[o] <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      out_vld_q <= '0;
      out_ch_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int o = 0; o < RADIX; o++) state_q[o] <= state_d[o];
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      out_vld_q <= out_vld_d;
      out_ch_q  <= out_ch_d;
      err_q     <= err_d;
    end
  end

  assign out_vld   = out_vld_q;
  assign out_ch    = out_ch_q;
  assign err_proto = err_q;
endmodule

// File: tb/tb_sw4_alloc.sv
// tb_sw4_alloc: directed and random checks of sw4_alloc (ADR_LSB=0 and 4) against a packet-level model
module tb_sw4_alloc;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       in_vld = '0;
  logic [3:0]       out_rdy = 4'hF;
  logic [3:0][17:0] in_ch = '0;
  logic [3:0]       rdy0, rdy4, ov0, ov4;
  logic [3:0][17:0] oc0, oc4;
  logic             err0, err4;

  always #5 clk = ~clk;

  sw4_alloc #(.CHANNEL_WIDTH(18), .ADR_LSB(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_ch(in_ch), .in_rdy(rdy0),
    .out_vld(ov0), .out_ch(oc0), .out_rdy(out_rdy), .err_proto(err0));
  sw4_alloc #(.CHANNEL_WIDTH(18), .ADR_LSB(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_ch(in_ch), .in_rdy(rdy4),
    .out_vld(ov4), .out_ch(oc4), .out_rdy(out_rdy), .err_proto(err4));

  int checks = 0;
  int failures = 0;

  // model per instance u (0: digit at bits 1:0, 1: digit at bits 5:4); lk = owning input or -1
  int          lk   [2][4];
  int          ptr  [2][4];
  int          acc  [2][4];
  bit          m_ov [2][4];
  logic [17:0] m_oc [2][4];
  bit          m_err[2];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dst(int u, logic [17:0] f);
    return u != 0 ? int'(f[5:4]) : int'(f[1:0]);
  endfunction

  function automatic bit owns(int u, int i);
    for (int o = 0; o < 4; o++) if (lk[u][o] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_rdy(int u);
    logic [3:0] r = '0;
    for (int o = 0; o < 4; o++) if (acc[u][o] >= 0) r[acc[u][o]] = 1'b1;
    return r;
  endfunction

  task automatic model_rst();
    for (int u = 0; u < 2; u++) begin
      m_err[u] = 1'b0;
      for (int o = 0; o < 4; o++) begin
        lk[u][o] = -1; ptr[u][o] = 0; acc[u][o] = -1; m_ov[u][o] = 1'b0; m_oc[u][o] = '0;
      end
    end
  endtask

  task automatic model_eval();
    for (int u = 0; u < 2; u++)
      for (int o = 0; o < 4; o++) begin
        acc[u][o] = -1;
        if (!m_ov[u][o] || out_rdy[o]) begin
          if (lk[u][o] < 0) begin
            for (int k = 0; k < 4; k++) begin
              int i = (ptr[u][o] + k) % 4;
              if (in_vld[i] && in_ch[i][17] && !owns(u, i) && dst(u, in_ch[i]) == o) begin
                acc[u][o] = i;
                break;
              end
            end
          end else if (in_vld[lk[u][o]] && !in_ch[lk[u][o]][17]) begin
            acc[u][o] = lk[u][o];
          end
        end
      end
  endtask

  task automatic model_clock();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4; i++)
        if (in_vld[i] && (in_ch[i][17] ? owns(u, i) : !owns(u, i))) m_err[u] = 1'b1;
      for (int o = 0; o < 4; o++) begin
        int a = acc[u][o];
        if (!m_ov[u][o] || out_rdy[o]) begin
          m_ov[u][o] = a >= 0;
          if (a >= 0) m_oc[u][o] = in_ch[a];
        end
        if (a >= 0) begin
          if (lk[u][o] < 0) begin
            ptr[u][o] = (a + 1) % 4;
            if (!in_ch[a][16]) lk[u][o] = a;
          end else if (in_ch[a][16]) begin
            lk[u][o] = -1;
          end
        end
      end
    end
  endtask

  task automatic pre();
    #1;
    model_eval();
    chk("in_rdy_lsb0", 72'(rdy0), 72'(exp_rdy(0)));
    chk("in_rdy_lsb4", 72'(rdy4), 72'(exp_rdy(1)));
  endtask

  task automatic post();
    logic [3:0] ev0, ev4;
    logic [3:0][17:0] ec0, ec4;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    for (int o = 0; o < 4; o++) begin
      ev0[o] = m_ov[0][o]; ec0[o] = m_oc[0][o];
      ev4[o] = m_ov[1][o]; ec4[o] = m_oc[1][o];
    end
    chk("out_vld_lsb0", 72'(ov0), 72'(ev0));
    chk("out_ch_lsb0", 72'(oc0), 72'(ec0));
    chk("err_lsb0", 72'(err0), 72'(m_err[0]));
    chk("out_vld_lsb4", 72'(ov4), 72'(ev4));
    chk("out_ch_lsb4", 72'(oc4), 72'(ec4));
    chk("err_lsb4", 72'(err4), 72'(m_err[1]));
  endtask

  task automatic cyc();
    pre();
    post();
  endtask

  task automatic setin(int i, bit v, bit h, bit t, logic [15:0] p);
    in_vld[i] = v;
    in_ch[i]  = {h, t, p};
  endtask

  int         rem  [4];
  bit         first[4];
  bit         need [4];
  logic [3:0] r;

  initial begin
    model_rst();
    for (int i = 0; i < 4; i++) setin(i, 1, 1, 1, 16'h0001);
    #1;
    chk("rst_in_rdy", 72'(rdy0), 72'(0));
    chk("rst_out_vld", 72'(ov0), 72'(0));
    chk("rst_out_ch", 72'(oc0), 72'(0));
    chk("rst_err", 72'(err0), 72'(0));
    in_vld = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // single-flit packet input 2 -> output 3
    setin(2, 1, 1, 1, 16'h0003);
    pre();
    chk("single_rdy", 72'(rdy0), 72'(4'b0100));
    post();
    chk("single_vld", 72'(ov0), 72'(4'b1000));
    chk("single_ch", 72'(oc0[3]), 72'(18'h30003));
    in_vld = '0;
    setin(0, 1, 1, 1, 16'h0003);
    pre();
    chk("single_idle", 72'(rdy0), 72'(4'b0001));
    post();
    in_vld = '0;

    // all inputs contend for output 1
    for (int i = 0; i < 4; i++) setin(i, 1, 1, 1, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      pre();
      chk("contention_grant", 72'(rdy0), 72'(4'b0001 << (k % 4)));
      post();
    end
    in_vld = '0;
    cyc();

    // wormhole lock on output 2 by input 1, input 0 waits
    setin(1, 1, 1, 0, 16'h0002);
    pre(); chk("wh_head_rdy", 72'(rdy0[1]), 72'(1)); post();
    chk("wh_ch0", 72'(oc0[2]), 72'(18'h20002));
    setin(1, 1, 0, 0, 16'hAAAA);
    setin(0, 1, 1, 1, 16'h0002);
    pre(); chk("wh_block1", 72'(rdy0[0]), 72'(0)); post();
    chk("wh_ch1", 72'(oc0[2]), 72'(18'h0AAAA));
    setin(1, 1, 0, 0, 16'hBBBB);
    pre(); chk("wh_block2", 72'(rdy0[0]), 72'(0)); post();
    chk("wh_ch2", 72'(oc0[2]), 72'(18'h0BBBB));
    setin(1, 1, 0, 1, 16'hCCCC);
    pre(); chk("wh_block3", 72'(rdy0[0]), 72'(0)); chk("wh_tail_rdy", 72'(rdy0[1]), 72'(1)); post();
    chk("wh_ch3", 72'(oc0[2]), 72'(18'h1CCCC));
    in_vld[1] = 1'b0;
    pre(); chk("wh_grant", 72'(rdy0[0]), 72'(1)); post();
    chk("wh_ch4", 72'(oc0[2]), 72'(18'h30002));
    in_vld = '0;
    cyc();

    // backpressure on output 0 mid-packet from input 3
    setin(3, 1, 1, 0, 16'h0000); cyc();
    setin(3, 1, 0, 0, 16'h1111); cyc();
    chk("bp_ch_pre", 72'(oc0[0]), 72'(18'h01111));
    setin(3, 1, 0, 0, 16'h2222);
    out_rdy = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      pre(); chk("bp_stall_rdy", 72'(rdy0[3]), 72'(0)); post();
      chk("bp_hold_ch", 72'(oc0[0]), 72'(18'h01111));
      chk("bp_hold_vld", 72'(ov0[0]), 72'(1));
    end
    out_rdy = 4'hF;
    cyc(); chk("bp_resume1", 72'(oc0[0]), 72'(18'h02222));
    setin(3, 1, 0, 1, 16'h3333);
    cyc(); chk("bp_resume2", 72'(oc0[0]), 72'(18'h13333));
    in_vld = '0;
    cyc();

    // digit at bits 5:4, then a stray body flit
    chk("lsb4_err_pre", 72'(err4), 72'(0));
    setin(0, 1, 1, 1, 16'h0020);
    pre(); chk("lsb4_rdy", 72'(rdy4[0]), 72'(1)); post();
    chk("lsb4_vld", 72'(ov4[2]), 72'(1));
    chk("lsb4_ch", 72'(oc4[2]), 72'(18'h30020));
    in_vld = '0;
    setin(2, 1, 0, 0, 16'h5555);
    for (int k = 0; k < 3; k++) begin
      pre(); chk("stray_rdy", 72'(rdy4[2]), 72'(0)); post();
      chk("stray_err", 72'(err4), 72'(1));
    end
    in_vld = '0;
    cyc();
    chk("stray_err_sticky", 72'(err4), 72'(1));

    // reset during the second flit of a 3-flit packet
    setin(0, 1, 1, 0, 16'h0001); cyc();
    setin(0, 1, 0, 0, 16'h4444);
    pre();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld0", 72'(ov0), 72'(0));
    chk("mid_rst_vld4", 72'(ov4), 72'(0));
    chk("mid_rst_rdy", 72'(rdy0), 72'(0));
    chk("mid_rst_err", 72'(err0), 72'(0));
    model_rst();
    in_vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    setin(0, 1, 1, 1, 16'h0001);
    pre(); chk("post_rst_rdy", 72'(rdy0[0]), 72'(1)); post();
    chk("post_rst_ch", 72'(oc0[1]), 72'(18'h30001));
    in_vld = '0;
    cyc();

    // random well-formed packets on every input, random downstream stalls
    for (int i = 0; i < 4; i++) begin rem[i] = 0; first[i] = 1'b0; need[i] = 1'b1; end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (need[i]) begin
          if (rem[i] == 0) begin rem[i] = $urandom_range(1, 4); first[i] = 1'b1; end
          in_ch[i] = {first[i], rem[i] == 1, 16'($urandom)};
          need[i] = 1'b0;
        end
        in_vld[i] = $urandom_range(0, 3) != 0;
      end
      out_rdy = 4'($urandom) | 4'($urandom);
      pre();
      r = exp_rdy(0);
      post();
      for (int i = 0; i < 4; i++)
        if (r[i]) begin first[i] = 1'b0; rem[i]--; need[i] = 1'b1; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
